// File: rtl/ascii_operand_loader_pkg.sv
// Shared definitions for the ASCII operand loader.
// ASCII constants, loader state encoding and character-class helpers.
package ascii_operand_loader_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        GET_X   = 2'd0,
        GET_Y   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == CH_LF) || (c == CH_CR);
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/ascii_operand_loader_dec_accum.sv
// Decimal digit accumulator: acc = acc*10 + digit, with digit count.
// Ports: clk, rst_n, clr, push_digit, digit[3:0] -> value, count, full.
module dec_accum #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push_digit,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam logic [WIDTH+3:0] TEN = (WIDTH + 4)'(10);

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    // Widened multiply-add; the parameter bound guarantees no truncation loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (push_digit) begin
            acc <= WIDTH'({4'b0, acc} * TEN + {{WIDTH{1'b0}}, digit});
            cnt <= cnt + CW'(1);
        end
    end

    assign value = acc;
    assign count = cnt;
    assign full  = (cnt == CW'(DIGITS));

endmodule

// File: rtl/ascii_operand_loader.sv
// Converts ASCII decimal keystrokes into an x/y operand pair for the adder.
// Ports: clk, rst_n, ch_valid/ch_data/ch_ready in; op_x/op_y/op_valid/op_ready out; err pulse.
module ascii_operand_loader
    import ascii_operand_loader_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch_valid,
    input  logic [7:0]       ch_data,
    output logic             ch_ready,
    output logic [WIDTH-1:0] op_x,
    output logic [WIDTH-1:0] op_y,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             err
);

    localparam int CW = $clog2(DIGITS + 1);

    if (pow10(DIGITS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("DIGITS decimal digits do not fit in WIDTH bits");
    end

    state_t           state;
    logic             accept;
    logic             dig;
    logic             term;
    logic             push;
    logic             reject;
    logic             load;
    logic             clr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             full;

    assign ch_ready = (state != PRESENT);
    assign accept   = ch_valid && ch_ready;
    assign dig      = is_digit(ch_data);
    assign term     = is_term(ch_data);

    // Extra digits and non-digit bytes both discard the partial operand.
    assign reject = accept && ((dig && full) || (!dig && !term));
    assign push   = accept && dig && !full;
    // Empty terminators are ignored so CR/LF pairs are harmless.
    assign load   = accept && term && (cnt != '0);
    assign clr    = reject || load;

    dec_accum #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS),
        .CW     (CW)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .push_digit (push),
        .digit      (ch_data[3:0]),
        .value      (acc),
        .count      (cnt),
        .full       (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= GET_X;
            op_x     <= '0;
            op_y     <= '0;
            op_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= reject;
            unique case (state)
                GET_X: begin
                    if (load) begin
                        op_x  <= acc;
                        state <= GET_Y;
                    end
                end
                GET_Y: begin
                    if (load) begin
                        op_y     <= acc;
                        op_valid <= 1'b1;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Operands are kept after transfer; only valid drops.
                    if (op_valid && op_ready) begin
                        op_valid <= 1'b0;
                        state    <= GET_X;
                    end
                end
                default: state <= GET_X;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_operand_loader.sv
// Directed bench for ascii_operand_loader with an expected-pair scoreboard.
// Also models the downstream 8-bit adder to check sum/carry.
module tb_ascii_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;
    logic [7:0] op_x;
    logic [7:0] op_y;
    logic       op_valid;
    logic       op_ready;
    logic       err;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pair_t;

    pair_t sb[$];
    int    total  = 0;
    int    passed = 0;

    ascii_operand_loader #(.WIDTH(8), .DIGITS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .op_x     (op_x),
        .op_y     (op_y),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic exp_err);
        int n;
        n = 0;
        while (!ch_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ch_ready) check("send_ready_timeout", ch_ready, 1);
        ch_valid = 1'b1;
        ch_data  = c;
        tick();
        ch_valid = 1'b0;
        check($sformatf("err_after_%02h", c), err, exp_err);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    task automatic wait_pair(input string tag);
        pair_t e;
        int    n;
        n = 0;
        while (!op_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, op_valid, 1);
        e = sb.pop_front();
        check({tag, "_x"}, op_x, e.x);
        check({tag, "_y"}, op_y, e.y);
    endtask

    task automatic handshake(input string tag);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check({tag, "_valid_drop"}, op_valid, 0);
        check({tag, "_ready_back"}, ch_ready, 1);
    endtask

    task automatic check_adder(input string tag, input int s, input int c);
        logic [8:0] sum;
        sum = {1'b0, op_x} + {1'b0, op_y};
        check({tag, "_s"}, sum[7:0], s);
        check({tag, "_c"}, sum[8], c);
    endtask

    initial begin
        rst_n    = 1'b0;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        op_ready = 1'b0;
        repeat (3) tick();
        check("rst_x", op_x, 0);
        check("rst_y", op_y, 0);
        check("rst_valid", op_valid, 0);
        check("rst_err", err, 0);
        check("rst_ready", ch_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        sb.push_back('{x: 8'd12, y: 8'd34});
        send_str("12\n");
        send_str("34\n");
        wait_pair("p12_34");
        check("p12_34_chready", ch_ready, 0);
        repeat (3) tick();
        check("p12_34_hold", op_valid, 1);
        check("p12_34_holdx", op_x, 12);
        check_adder("add46", 46, 0);
        handshake("p12_34");
        check("p12_34_keepx", op_x, 12);

        sb.push_back('{x: 8'd99, y: 8'd99});
        send_str("99\n");
        send_str("99\n");
        wait_pair("p99_99");
        check_adder("add198", 198, 0);
        handshake("p99_99");

        send("2", 1'b0);
        send("5", 1'b0);
        send("5", 1'b1);
        tick();
        check("err_width", err, 0);
        send_str("7\n");
        check("x_after_overflow", op_x, 7);
        sb.push_back('{x: 8'd7, y: 8'd1});
        send_str("1\n");
        wait_pair("p7_1");
        handshake("p7_1");

        sb.push_back('{x: 8'd5, y: 8'd0});
        send(8'h0A, 1'b0);
        send(8'h0D, 1'b0);
        send("5", 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        send_str("0\n");
        wait_pair("p5_0");
        handshake("p5_0");

        send("4", 1'b0);
        send("A", 1'b1);
        send("A", 1'b1);
        send_str("8\n");
        check("x_after_bad", op_x, 8);
        sb.push_back('{x: 8'd8, y: 8'd3});
        send_str("3\n");
        wait_pair("p8_3");

        ch_data  = "9";
        ch_valid = 1'b1;
        repeat (3) tick();
        check("present_x", op_x, 8);
        check("present_y", op_y, 3);
        check("present_chready", ch_ready, 0);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("xfer_valid_drop", op_valid, 0);
        ch_data = "6";
        tick();
        ch_valid = 1'b0;
        send(8'h0A, 1'b0);
        check("x_after_xfer", op_x, 6);
        sb.push_back('{x: 8'd6, y: 8'd2});
        send_str("2\n");
        wait_pair("p6_2");
        handshake("p6_2");

        send_str("21\n");
        check("x21", op_x, 21);
        send("3", 1'b0);
        send("A", 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x", op_x, 0);
        check("mid_rst_y", op_y, 0);
        check("mid_rst_valid", op_valid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_ready", ch_ready, 1);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", op_valid, 0);
        sb.push_back('{x: 8'd1, y: 8'd2});
        send_str("1\n");
        send_str("2\n");
        wait_pair("p1_2");
        handshake("p1_2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ascii_operand_loader.md
Name: ascii_operand_loader

Overview:
- Upstream input stage for the 8-bit ripple adder.
- Accepts a byte stream of ASCII keystrokes over a valid/ready handshake and converts decimal digit strings into binary operands.
- After two terminated operands, presents the pair as x/y, which the adder consumes combinationally.
- Holds the pair with a valid/ready handshake until the consumer (result capture/display logic) acknowledges.

Parameters:
- WIDTH, 8, operand width in bits; matches adder x/y width.
- DIGITS, 2, maximum decimal digits per operand. Elaboration-time check required: 10^DIGITS-1 <= 2^WIDTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ch_valid  input  1  ch_data holds a keystroke.
- ch_data  input  8  ASCII character.
- ch_ready  output  1  loader can accept a character this cycle.
- op_x  output  WIDTH  first operand, to adder x.
- op_y  output  WIDTH  second operand, to adder y.
- op_valid  output  1  op_x/op_y hold a complete pair.
- op_ready  input  1  consumer has taken the pair.
- err  output  1  one-cycle pulse on a rejected operand.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=GET_X; acc=0; digit count=0.
  - op_x=0, op_y=0, op_valid=0, err=0.
  - ch_ready=1, because ch_ready is combinational (state != PRESENT).
- Character accept: ch_valid && ch_ready at a rising edge. Each accepted character takes effect in exactly one cycle. No internal buffering beyond acc.
- States:
  - GET_X: building operand x.
  - GET_Y: building operand y.
  - PRESENT: pair held, ch_ready=0.
- Digit ('0'..'9', 0x30..0x39):
  - If count < DIGITS: acc <= acc*10 + (ch_data-0x30), count++.
  - Arithmetic is done in WIDTH+4 bits, then truncated; cannot overflow under the parameter constraint.
  - If count == DIGITS (too many digits): err pulses next cycle, acc<=0, count<=0, state unchanged. The operand is discarded and must be re-entered.
- Terminator (LF 0x0A or CR 0x0D):
  - count == 0: ignored, no err. Consecutive CR/LF is therefore harmless.
  - GET_X with count > 0: op_x <= acc; acc,count <= 0; state <= GET_Y.
  - GET_Y with count > 0: op_y <= acc; acc,count <= 0; state <= PRESENT; op_valid=1 from the next cycle.
  - Latency: terminator of y accepted at edge N, op_valid high after edge N.
- Any other byte: same handling as too-many-digits (err pulse, discard current operand, state unchanged). Previously latched op_x is kept.
- PRESENT:
  - op_x, op_y, op_valid held stable until op_valid && op_ready at an edge.
  - On that edge: op_valid<=0, state<=GET_X. op_x/op_y retain their values (not cleared).
  - ch_ready returns to 1 the cycle after the transfer. No character is accepted in the transfer cycle.
- Simultaneous events:
  - ch_valid in PRESENT is ignored, since ch_ready=0.
  - op_ready outside PRESENT has no effect.
- err: registered, exactly one cycle wide per rejected character. Back-to-back rejects give back-to-back pulses.
- Reset mid-operation: a partial operand, pending op_valid, and pending err are all discarded immediately. No spurious op_valid after release.

Decomposition:
- Shared package holds:
  - ASCII constants: CH_0=8'h30, CH_9=8'h39, CH_LF=8'h0A, CH_CR=8'h0D.
  - Loader state enum: GET_X, GET_Y, PRESENT.
  - Helper function is_digit.
- One sub-module, dec_accum: the acc/count registers with inputs clr, push_digit, digit[3:0] and outputs value, count, full. It is reusable by future multi-digit input stages.
- Top level holds the FSM, operand registers and handshake.

Test Plan:
- Send "12\n", "34\n" with op_ready=0 -> op_x=12, op_y=34, op_valid=1 held; ch_ready=0. Pulse op_ready -> op_valid=0 next cycle; adder output s=46, c=0.
- Send "99\n", "99\n" -> op_x=99, op_y=99; adder s=198, c=0. Send "255"-style "2","5","5" -> err pulse on the third digit, acc cleared; then "7\n" -> op_x=7.
- Send "\n", "\r", "5\r", "\n", "0\n" -> empty terminators ignored, no err; op_x=5, op_y=0, op_valid=1.
- Send "4", "A" -> err one cycle, operand discarded; then "8\n" in GET_X -> op_x=8, not 48.
- Drive ch_valid continuously during PRESENT -> no characters accepted, op_x/op_y unchanged. After the handshake, the next character is consumed one cycle later.
- Assert rst_n=0 after "3" is accepted in GET_Y with op_x=21 -> op_x=0, op_y=0, op_valid=0, err=0, ch_ready=1. After release, "1\n","2\n" -> op_x=1, op_y=2.
